// File: rtl/cnt_sequencer_if.sv
// cnt_sequencer_if: control and observation signals between a counter
// sequencer and the logic that starts it and owns the counter datapath.
interface cnt_sequencer_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic             stop;
  logic             pause;
  logic             reload;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] q;
  logic             ec;
  logic             cr;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       passes;

  modport master (
    output start, stop, pause, reload, term, q,
    input  ec, cr, busy, done, err, passes
  );

  modport slave (
    input  start, stop, pause, reload, term, q,
    output ec, cr, busy, done, err, passes
  );

endinterface

// File: rtl/cnt_sequencer.sv
// cnt_sequencer: sequencing controller for an enable-gated counter.
// A run clears the counter for CLR_CYCLES cycles, then enables it until q
// equals the terminal value latched at start, then pulses done and either
// reloads (same terminal value) or returns to idle. A run that needs TMO
// enabled cycles without matching lands in a sticky error state.
module cnt_sequencer #(
  parameter int WIDTH      = 4,
  parameter int CLR_CYCLES = 2,
  parameter int TMO        = 64
) (
  input  logic           clk,
  input  logic           r,
  cnt_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE,
    ERR
  } state_t;

  // Last clear-phase count and last enabled cycle before a timeout.
  localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] term_r;
  logic [WIDTH-1:0] term_n;
  logic [3:0]       clr_cnt;
  logic [3:0]       clr_n;
  logic [7:0]       run_cyc;
  logic [7:0]       run_n;
  logic [7:0]       passes_r;
  logic [7:0]       passes_n;
  logic             err_r;
  logic             err_n;
  logic             match;
  logic             ec_c;
  logic             cr_c;
  logic             done_c;

  assign match = (bus.q == term_r);

  // Register the state and all bookkeeping; reset forces everything idle.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state    <= IDLE;
      term_r   <= '0;
      clr_cnt  <= '0;
      run_cyc  <= '0;
      passes_r <= '0;
      err_r    <= 1'b0;
    end else begin
      state    <= state_n;
      term_r   <= term_n;
      clr_cnt  <= clr_n;
      run_cyc  <= run_n;
      passes_r <= passes_n;
      err_r    <= err_n;
    end
  end

  // Next-state and counter-control decode; stop beats everything else.
  always_comb begin
    state_n  = state;
    term_n   = term_r;
    clr_n    = clr_cnt;
    run_n    = run_cyc;
    passes_n = passes_r;
    err_n    = err_r;
    ec_c     = 1'b0;
    cr_c     = 1'b0;
    done_c   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n  = CLEAR;
          term_n   = bus.term;
          err_n    = 1'b0;
          passes_n = '0;
          clr_n    = '0;
        end
      end

      CLEAR: begin
        cr_c  = 1'b1;
        run_n = '0;
        if (bus.stop) begin
          state_n = IDLE;
          clr_n   = '0;
        end else if (clr_cnt == CLR_LAST) begin
          state_n = RUN;
          clr_n   = '0;
        end else begin
          clr_n = clr_cnt + 4'd1;
        end
      end

      RUN: begin
        ec_c = !bus.pause && !match;
        if (bus.stop) begin
          state_n = IDLE;
        end else if (match) begin
          state_n = DONE;
        end else if (ec_c) begin
          run_n = run_cyc + 8'd1;
          if (run_cyc == TMO_LAST) begin
            state_n = ERR;
            err_n   = 1'b1;
          end
        end
      end

      DONE: begin
        if (bus.stop) begin
          state_n = IDLE;
        end else begin
          done_c   = 1'b1;
          passes_n = passes_r + 8'd1;
          if (bus.reload) begin
            state_n = CLEAR;
            run_n   = '0;
            clr_n   = '0;
          end else if (bus.start) begin
            state_n = CLEAR;
            term_n  = bus.term;
            run_n   = '0;
            clr_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end

      ERR: begin
        if (bus.stop) begin
          state_n = IDLE;
        end else if (bus.start) begin
          state_n = CLEAR;
          term_n  = bus.term;
          err_n   = 1'b0;
          clr_n   = '0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.ec     = ec_c;
  assign bus.cr     = cr_c;
  assign bus.done   = done_c;
  assign bus.busy   = (state == CLEAR) || (state == RUN) || (state == DONE);
  assign bus.err    = err_r;
  assign bus.passes = passes_r;

endmodule

// File: tb/tb_cnt_sequencer.sv
// tb_cnt_sequencer: drives two sequencers (normal and short timeout), each
// with a behavioural down-counter on q, and compares per-cycle cr/ec/done
// traces against sequences built from the run rules.
module tb_cnt_sequencer;

  localparam int W    = 4;
  localparam int CLRC = 2;

  logic clk = 1'b0;
  logic r   = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  logic [2:0] log_q[$];
  logic [2:0] exp_q[$];
  int         t_ec   = 0;
  int         t_done = 0;

  cnt_sequencer_if #(.WIDTH(W)) sif ();
  cnt_sequencer_if #(.WIDTH(W)) tif ();

  cnt_sequencer #(.WIDTH(W), .CLR_CYCLES(CLRC), .TMO(64)) dut (
    .clk(clk), .r(r), .bus(sif.slave)
  );

  cnt_sequencer #(.WIDTH(W), .CLR_CYCLES(CLRC), .TMO(8)) dut_t (
    .clk(clk), .r(r), .bus(tif.slave)
  );

  always #5 clk = ~clk;

  // Counter model for the main instance: cr reloads 15, ec counts down.
  always @(posedge clk or posedge r) begin
    if (r) sif.q <= 4'hF;
    else if (sif.cr) sif.q <= 4'hF;
    else if (sif.ec) sif.q <= sif.q - 4'd1;
  end

  // Counter model for the short-timeout instance.
  always @(posedge clk or posedge r) begin
    if (r) tif.q <= 4'hF;
    else if (tif.cr) tif.q <= 4'hF;
    else if (tif.ec) tif.q <= tif.q - 4'd1;
  end

  // Per-cycle trace of {cr, ec, done} for the main instance.
  always @(negedge clk) log_q.push_back({sif.cr, sif.ec, sif.done});

  // Running enable and done counts for the short-timeout instance.
  always @(negedge clk) begin
    if (tif.ec === 1'b1) t_ec++;
    if (tif.done === 1'b1) t_done++;
  end

  // Expected trace of one run: clear phase, enabled cycles with an optional
  // pause gap, the matching cycle, then the done cycle.
  task automatic model_pass(input int term, input int pause_at, input int pause_len);
    int n;
    n = 15 - term;
    for (int i = 0; i < CLRC; i++) exp_q.push_back(3'b100);
    for (int i = 0; i < n; i++) begin
      if (i == pause_at)
        for (int j = 0; j < pause_len; j++) exp_q.push_back(3'b000);
      exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b001);
  endtask

  function automatic int first_diff(input int base);
    if (log_q.size() - base != exp_q.size()) return -2;
    for (int i = 0; i < exp_q.size(); i++)
      if (log_q[base + i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int count_ec(input int base);
    int n;
    n = 0;
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i][1] === 1'b1) n++;
    return n;
  endfunction

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (sif.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sif.start = 0; sif.stop = 0; sif.pause = 0; sif.reload = 0; sif.term = '0;
    tif.start = 0; tif.stop = 0; tif.pause = 0; tif.reload = 0; tif.term = '0;
    #1 r = 1'b1;
    #2;
    compared++; if (sif.ec !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ec: got %b expected 0", sif.ec); end
    compared++; if (sif.cr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cr: got %b expected 0", sif.cr); end
    compared++; if (sif.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", sif.busy); end
    compared++; if (sif.done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", sif.done); end
    compared++; if (sif.err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b expected 0", sif.err); end
    compared++; if (sif.passes !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_passes: got %0d expected 0", sif.passes); end
    compared++; if (tif.err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_t_err: got %b expected 0", tif.err); end
    repeat (2) @(posedge clk);
    #3 r = 1'b0;
    @(posedge clk); #1;
    compared++; if (sif.busy !== 1'b0 || sif.ec !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_idle: got busy=%b ec=%b expected 0 0", sif.busy, sif.ec); end
  endtask

  task automatic test_one_shot();
    for (int trial = 0; trial < 4; trial++) begin
      int t; int base; int d; bit ok;
      t = (trial == 0) ? 10 : int'($urandom_range(0, 14));
      exp_q.delete();
      model_pass(t, -1, 0);
      @(posedge clk); #1;
      sif.term = 4'(t); sif.reload = 1'b0; sif.start = 1'b1;
      @(posedge clk); #1;
      base = log_q.size();
      if (trial != 0) begin
        sif.term = 4'($urandom);
        @(posedge clk); #1;
      end
      sif.start = 1'b0;
      wait_idle(60, ok);
      compared++; if (!ok) begin mismatched++; $display("[TB] FAIL one_shot_idle: got busy=%b expected 0 within 60 cycles", sif.busy); end
      d = first_diff(base);
      compared++; if (d != -1) begin mismatched++; $display("[TB] FAIL one_shot_trace: got divergence at %0d expected none (term=%0d)", d, t); end
      compared++; if (count_ec(base) != 15 - t) begin mismatched++; $display("[TB] FAIL one_shot_ec: got %0d expected %0d", count_ec(base), 15 - t); end
      compared++; if (sif.passes !== 8'd1) begin mismatched++; $display("[TB] FAIL one_shot_passes: got %0d expected 1", sif.passes); end
      compared++; if (sif.q !== 4'(t)) begin mismatched++; $display("[TB] FAIL one_shot_q: got %0d expected %0d", sif.q, t); end
    end
  endtask

  task automatic test_auto_reload();
    int base; int d;
    exp_q.delete();
    for (int p = 0; p < 4; p++) model_pass(13, -1, 0);
    exp_q.push_back(3'b100);
    for (int i = 0; i < 10; i++) exp_q.push_back(3'b000);
    @(posedge clk); #1;
    sif.term = 4'd13; sif.reload = 1'b1; sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    base = log_q.size();
    sif.term = 4'($urandom);
    repeat (24) begin @(posedge clk); #1; end
    compared++; if (sif.passes !== 8'd4) begin mismatched++; $display("[TB] FAIL reload_passes: got %0d expected 4", sif.passes); end
    sif.stop = 1'b1;
    @(posedge clk); #1;
    sif.stop = 1'b0; sif.reload = 1'b0;
    compared++; if (sif.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reload_stop_busy: got %b expected 0", sif.busy); end
    compared++; if (sif.passes !== 8'd4) begin mismatched++; $display("[TB] FAIL reload_stop_passes: got %0d expected 4", sif.passes); end
    repeat (10) begin @(posedge clk); #1; end
    d = first_diff(base);
    compared++; if (d != -1) begin mismatched++; $display("[TB] FAIL reload_trace: got divergence at %0d expected none", d); end
  endtask

  task automatic test_pause();
    for (int trial = 0; trial < 3; trial++) begin
      int t; int n; int k; int base; int d; bit ok;
      t = (trial == 0) ? 0 : int'($urandom_range(0, 12));
      n = 15 - t;
      k = (trial == 0) ? 4 : int'($urandom_range(0, n - 1));
      exp_q.delete();
      model_pass(t, k, 3);
      @(posedge clk); #1;
      sif.term = 4'(t); sif.reload = 1'b0; sif.start = 1'b1;
      @(posedge clk); #1;
      sif.start = 1'b0;
      base = log_q.size();
      repeat (2 + k) begin @(posedge clk); #1; end
      sif.pause = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      compared++; if (sif.q !== 4'(15 - k)) begin mismatched++; $display("[TB] FAIL pause_q_frozen: got %0d expected %0d", sif.q, 15 - k); end
      sif.pause = 1'b0;
      wait_idle(60, ok);
      compared++; if (!ok) begin mismatched++; $display("[TB] FAIL pause_idle: got busy=%b expected 0 within 60 cycles", sif.busy); end
      d = first_diff(base);
      compared++; if (d != -1) begin mismatched++; $display("[TB] FAIL pause_trace: got divergence at %0d expected none (term=%0d k=%0d)", d, t, k); end
      compared++; if (count_ec(base) != n) begin mismatched++; $display("[TB] FAIL pause_ec: got %0d expected %0d", count_ec(base), n); end
    end
  endtask

  task automatic test_match_and_timeout();
    int base; int d; int ec0; int dn0; bit ok;
    exp_q.delete();
    model_pass(15, -1, 0);
    @(posedge clk); #1;
    sif.term = 4'd15; sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    base = log_q.size();
    wait_idle(20, ok);
    d = first_diff(base);
    compared++; if (!ok || d != -1) begin mismatched++; $display("[TB] FAIL immediate_trace: got ok=%0d divergence=%0d expected 1 -1", ok, d); end
    compared++; if (count_ec(base) != 0) begin mismatched++; $display("[TB] FAIL immediate_ec: got %0d expected 0", count_ec(base)); end

    ec0 = t_ec;
    @(posedge clk); #1;
    tif.term = 4'd0; tif.start = 1'b1;
    @(posedge clk); #1;
    tif.start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (tif.err === 1'b1) begin ok = 1'b1; break; end
    end
    compared++; if (!ok) begin mismatched++; $display("[TB] FAIL timeout_err: got %b expected 1 within 40 cycles", tif.err); end
    compared++; if (t_ec - ec0 != 8) begin mismatched++; $display("[TB] FAIL timeout_ec: got %0d expected 8", t_ec - ec0); end
    compared++; if (tif.busy !== 1'b0 || tif.ec !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_outputs: got busy=%b ec=%b expected 0 0", tif.busy, tif.ec); end
    repeat (3) begin @(posedge clk); #1; end
    compared++; if (t_ec - ec0 != 8 || tif.err !== 1'b1) begin mismatched++; $display("[TB] FAIL err_hold: got ec=%0d err=%b expected 8 1", t_ec - ec0, tif.err); end
    dn0 = t_done;
    tif.term = 4'd14; tif.start = 1'b1;
    @(posedge clk); #1;
    tif.start = 1'b0;
    compared++; if (tif.err !== 1'b0 || tif.busy !== 1'b1) begin mismatched++; $display("[TB] FAIL err_restart: got err=%b busy=%b expected 0 1", tif.err, tif.busy); end
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (tif.busy === 1'b0) begin ok = 1'b1; break; end
    end
    compared++; if (!ok || t_done - dn0 != 1 || tif.passes !== 8'd1) begin mismatched++; $display("[TB] FAIL err_rerun: got ok=%0d done=%0d passes=%0d expected 1 1 1", ok, t_done - dn0, tif.passes); end
  endtask

  task automatic test_priority();
    @(posedge clk); #1;
    sif.term = 4'd14; sif.reload = 1'b0; sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    compared++; if (sif.done !== 1'b1) begin mismatched++; $display("[TB] FAIL prio_in_done: got %b expected 1", sif.done); end
    sif.stop = 1'b1; sif.start = 1'b1; sif.term = 4'd3;
    @(posedge clk); #1;
    sif.stop = 1'b0; sif.start = 1'b0;
    compared++; if (sif.busy !== 1'b0 || sif.cr !== 1'b0) begin mismatched++; $display("[TB] FAIL prio_stop_start: got busy=%b cr=%b expected 0 0", sif.busy, sif.cr); end
    @(posedge clk); #1;
    compared++; if (sif.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL prio_stays_idle: got %b expected 0", sif.busy); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    sif.term = 4'd14; sif.reload = 1'b1; sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    compared++; if (sif.ec !== 1'b1 || sif.passes !== 8'd2) begin mismatched++; $display("[TB] FAIL areset_pre: got ec=%b passes=%0d expected 1 2", sif.ec, sif.passes); end
    #2 r = 1'b1;
    #1;
    compared++; if (sif.ec !== 1'b0 || sif.cr !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_ec_cr: got ec=%b cr=%b expected 0 0", sif.ec, sif.cr); end
    compared++; if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_busy_done: got busy=%b done=%b expected 0 0", sif.busy, sif.done); end
    compared++; if (sif.passes !== 8'd0) begin mismatched++; $display("[TB] FAIL areset_passes: got %0d expected 0", sif.passes); end
    sif.reload = 1'b0;
    @(posedge clk);
    #3 r = 1'b0;
    @(posedge clk); #1;
    compared++; if (sif.busy !== 1'b0 || sif.ec !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_after: got busy=%b ec=%b expected 0 0", sif.busy, sif.ec); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_match_and_timeout();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
